// File: rtl/ac97_link_if.sv
// ac97_link_if: AC-link serial inputs and parsed-word outputs of the link receiver
interface ac97_link_if #(parameter int PCM_WIDTH = 16);
  logic bit_en;
  logic sync;
  logic sdata;
  logic locked;
  logic [15:0] tag;
  logic [19:0] cmd_addr;
  logic [19:0] cmd_data;
  logic cmd_valid;
  logic [PCM_WIDTH-1:0] pcm_left;
  logic [PCM_WIDTH-1:0] pcm_right;
  logic pcm_valid;
  logic sync_err;
  modport master (
    output bit_en, sync, sdata,
    input  locked, tag, cmd_addr, cmd_data, cmd_valid, pcm_left, pcm_right, pcm_valid, sync_err
  );
  modport slave (
    input  bit_en, sync, sdata,
    output locked, tag, cmd_addr, cmd_data, cmd_valid, pcm_left, pcm_right, pcm_valid, sync_err
  );
endinterface

// File: rtl/ac97_link_receiver.sv
// ac97_link_receiver: locks onto AC-link frames via Sync and captures tag, command and PCM slots
module ac97_link_receiver #(
  parameter int PCM_WIDTH  = 16,
  parameter int FRAME_BITS = 256
) (
  input logic clk,
  input logic reset,
  ac97_link_if.slave link
);
  localparam int CW = $clog2(FRAME_BITS);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync_prev_q;
  logic [19:0] shift_q, shift_d, slot1_q;
  logic [PCM_WIDTH-1:0] slot3_q, pcm_left_q, pcm_right_q;
  logic [15:0] tag_q;
  logic [19:0] cmd_addr_q, cmd_data_q;
  logic cmd_valid_q, pcm_valid_q, sync_err_q;
  logic start, err, adv, sync_exp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= HUNT;
    else state_q <= state_d;
  always_comb begin
    sync_exp = cnt_q < CW'(16);
    start = link.bit_en && state_q == HUNT && link.sync && !sync_prev_q;
    err = link.bit_en && state_q == LOCKED && (link.sync != sync_exp);
    state_d = start ? LOCKED : err ? HUNT : state_q;
  end
  // An error on a capture bit suppresses adv, so the error always wins over a strobe
  always_comb begin
    adv = link.bit_en && state_q == LOCKED && !err;
    shift_d = {shift_q[18:0], link.sdata};
    cnt_d = start ? CW'(1) : err ? '0 :
            adv ? (cnt_q == CW'(FRAME_BITS - 1) ? '0 : cnt_q + CW'(1)) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      sync_prev_q <= 1'b1;
      shift_q <= '0;
      slot1_q <= '0;
      slot3_q <= '0;
      tag_q <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      pcm_left_q <= '0;
      pcm_right_q <= '0;
      cmd_valid_q <= 1'b0;
      pcm_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cmd_valid_q <= 1'b0;
      pcm_valid_q <= 1'b0;
      sync_err_q <= err;
      if (link.bit_en) begin
        shift_q <= shift_d;
        sync_prev_q <= link.sync;
      end
      if (adv) begin
        if (cnt_q == CW'(15)) tag_q <= shift_d[15:0];
        if (cnt_q == CW'(35)) slot1_q <= shift_d;
        if (cnt_q == CW'(55) && &tag_q[15:13]) begin
          cmd_addr_q <= slot1_q;
          cmd_data_q <= shift_d;
          cmd_valid_q <= 1'b1;
        end
        if (cnt_q == CW'(75)) slot3_q <= shift_d[19 -: PCM_WIDTH];
        if (cnt_q == CW'(95) && tag_q[15] && (tag_q[12] || tag_q[11])) begin
          if (tag_q[12]) pcm_left_q <= slot3_q;
          if (tag_q[11]) pcm_right_q <= shift_d[19 -: PCM_WIDTH];
          pcm_valid_q <= 1'b1;
        end
      end
    end
  assign link.locked    = state_q == LOCKED;
  assign link.tag       = tag_q;
  assign link.cmd_addr  = cmd_addr_q;
  assign link.cmd_data  = cmd_data_q;
  assign link.cmd_valid = cmd_valid_q;
  assign link.pcm_left  = pcm_left_q;
  assign link.pcm_right = pcm_right_q;
  assign link.pcm_valid = pcm_valid_q;
  assign link.sync_err  = sync_err_q;
endmodule

// File: tb/tb_ac97_link_receiver.sv
// tb_ac97_link_receiver: random-gap AC-link frames checked against a frame-level reference model
module tb_ac97_link_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0, bad = 0;
  int pv_cnt = 0, cv_cnt = 0, err_cnt = 0;
  ac97_link_if #(.PCM_WIDTH(16)) bus();
  ac97_link_receiver #(.PCM_WIDTH(16), .FRAME_BITS(256)) dut (.clk(clk), .reset(reset), .link(bus));
  always #5 clk = ~clk;
  // Reference model: bits of the current frame indexed by position
  logic bits [256];
  logic m_locked, m_prev;
  int m_pos;
  logic [15:0] e_tag;
  logic [19:0] e_ca, e_cd;
  logic [15:0] e_pl, e_pr;
  logic e_cv, e_pv, e_err;
  function automatic logic [19:0] word(input int s);
    logic [19:0] w = '0;
    for (int i = 0; i < 20; i++) w = {w[18:0], bits[s + i]};
    return w;
  endfunction
  task automatic model_reset();
    m_locked = 0; m_prev = 1; m_pos = 0;
    e_tag = '0; e_ca = '0; e_cd = '0; e_pl = '0; e_pr = '0;
    e_cv = 0; e_pv = 0; e_err = 0;
  endtask
  task automatic model(input logic be, input logic s, input logic d);
    logic [19:0] w;
    e_cv = 0; e_pv = 0; e_err = 0;
    if (!be) return;
    if (!m_locked) begin
      if (s && !m_prev) begin
        m_locked = 1; bits[0] = d; m_pos = 1;
      end
    end else if (s != (m_pos < 16)) begin
      e_err = 1; m_locked = 0;
    end else begin
      bits[m_pos] = d;
      if (m_pos == 15) for (int i = 0; i < 16; i++) e_tag[15 - i] = bits[i];
      if (m_pos == 55 && e_tag[15:13] == 3'b111) begin
        e_ca = word(16); e_cd = word(36); e_cv = 1;
      end
      if (m_pos == 95 && e_tag[15] && (e_tag[12] || e_tag[11])) begin
        w = word(56); if (e_tag[12]) e_pl = w[19:4];
        w = word(76); if (e_tag[11]) e_pr = w[19:4];
        e_pv = 1;
      end
      m_pos = (m_pos + 1) % 256;
    end
    m_prev = s;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("tag", 32'(bus.tag), 32'(e_tag));
    chk("cmd_addr", 32'(bus.cmd_addr), 32'(e_ca));
    chk("cmd_data", 32'(bus.cmd_data), 32'(e_cd));
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(e_cv));
    chk("pcm_left", 32'(bus.pcm_left), 32'(e_pl));
    chk("pcm_right", 32'(bus.pcm_right), 32'(e_pr));
    chk("pcm_valid", 32'(bus.pcm_valid), 32'(e_pv));
    chk("sync_err", 32'(bus.sync_err), 32'(e_err));
    if (bus.pcm_valid) pv_cnt++;
    if (bus.cmd_valid) cv_cnt++;
    if (bus.sync_err) err_cnt++;
  end
  task automatic step(input logic be, input logic s, input logic d);
    bus.bit_en = be; bus.sync = s; bus.sdata = d;
    @(posedge clk);
    if (!reset) model_reset(); else model(be, s, d);
    @(negedge clk);
  endtask
  task automatic bitx(input logic s, input logic d);
    int g = $urandom_range(0, 2);
    repeat (g) step(1'b0, 1'($urandom), 1'($urandom));
    step(1'b1, s, d);
  endtask
  task automatic clear_counts();
    pv_cnt = 0; cv_cnt = 0; err_cnt = 0;
  endtask
  // mode 0 clean, 1 sync low from bit k, 2 sync high bits 16..k, 3 reset at bit k
  task automatic frame(input logic [15:0] t, input logic [19:0] s1, input logic [19:0] s2,
                       input logic [19:0] s3, input logic [19:0] s4, input int mode, input int k);
    logic [255:0] v;
    logic sy;
    v = {t, s1, s2, s3, s4, 160'b0};
    for (int i = 96; i < 256; i++) v[255 - i] = 1'($urandom);
    for (int i = 0; i < 256; i++) begin
      if (mode == 3 && i == k) begin
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_pcm_left", 32'(bus.pcm_left), 32'd0);
        chk("rst_tag", 32'(bus.tag), 32'd0);
        repeat (3) @(negedge clk);
        #2 bus.sync = 1'b0; bus.bit_en = 1'b0; reset = 1'b1;
        return;
      end
      sy = i < 16;
      if (mode == 1 && i >= k && i < 16) sy = 1'b0;
      if (mode == 2 && i >= 16 && i <= k) sy = 1'b1;
      bitx(sy, v[255 - i]);
    end
  endtask
  initial begin
    bus.bit_en = 1'b0; bus.sync = 1'b1; bus.sdata = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_locked", 32'(bus.locked), 32'd0);
    chk("init_pcm_right", 32'(bus.pcm_right), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    clear_counts();
    repeat (5) bitx(1'b1, 1'($urandom));
    chk("held_high_no_lock", 32'(bus.locked), 32'd0);
    repeat (3) bitx(1'b0, 1'($urandom));
    repeat (3) frame(16'hF800, 20'h11111, 20'h22222, 20'h12345, 20'hABCDE, 0, 0);
    chk("three_frames_pv", 32'(pv_cnt), 32'd3);
    chk("pl_1234", 32'(bus.pcm_left), 32'h1234);
    chk("pr_abcd", 32'(bus.pcm_right), 32'hABCD);
    chk("locked_after", 32'(bus.locked), 32'd1);
    clear_counts();
    frame(16'h9000, 20'h0, 20'h0, 20'h0FFFF, 20'h55555, 0, 0);
    chk("left_only_pv", 32'(pv_cnt), 32'd1);
    chk("pl_0fff", 32'(bus.pcm_left), 32'h0FFF);
    chk("pr_hold", 32'(bus.pcm_right), 32'hABCD);
    clear_counts();
    frame(16'hE000, 20'h80260, 20'h1F1F0, 20'h33333, 20'h44444, 0, 0);
    chk("cmd_cv", 32'(cv_cnt), 32'd1);
    chk("cmd_no_pv", 32'(pv_cnt), 32'd0);
    chk("cmd_addr_lit", 32'(bus.cmd_addr), 32'h80260);
    chk("cmd_data_lit", 32'(bus.cmd_data), 32'h1F1F0);
    clear_counts();
    frame(16'hF800, 20'h0, 20'h0, 20'h11111, 20'h22222, 1, 8);
    chk("drop_err", 32'(err_cnt), 32'd1);
    chk("drop_no_pv", 32'(pv_cnt), 32'd0);
    chk("drop_unlocked", 32'(bus.locked), 32'd0);
    frame(16'hF800, 20'h0, 20'h0, 20'h6789A, 20'h13579, 0, 0);
    chk("relock_pl", 32'(bus.pcm_left), 32'h6789);
    chk("relock_pr", 32'(bus.pcm_right), 32'h1357);
    clear_counts();
    frame(16'hF800, 20'h0, 20'h0, 20'hAAAAA, 20'hBBBBB, 2, 20);
    chk("high_err", 32'(err_cnt), 32'd1);
    chk("high_unlocked", 32'(bus.locked), 32'd0);
    frame(16'hF800, 20'h0, 20'h0, 20'hCAFE0, 20'hBEEF0, 0, 0);
    chk("high_relock_pl", 32'(bus.pcm_left), 32'hCAFE);
    clear_counts();
    frame(16'hF800, 20'h0, 20'h0, 20'h99999, 20'h88888, 3, 70);
    chk("abort_no_pv", 32'(pv_cnt), 32'd0);
    repeat (2) bitx(1'b0, 1'($urandom));
    frame(16'hF800, 20'h0, 20'h0, 20'h24680, 20'h97531, 0, 0);
    chk("post_rst_pl", 32'(bus.pcm_left), 32'h2468);
    chk("post_rst_pr", 32'(bus.pcm_right), 32'h9753);
    for (int n = 0; n < 20; n++) begin
      int r = $urandom_range(0, 5);
      int md = r == 0 ? 1 : r == 1 ? 2 : 0;
      int k = md == 1 ? $urandom_range(1, 15) : $urandom_range(16, 40);
      frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), md, k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
